sram_token_arbiter: RTL

Parametrised, sample-synchronous owner of the single external SRAM port. The effect chain uses it to hand the SRAM to N clients (delay, looper, future memory effects) in a fixed chain order, once per audio sample. Compared with the fixed two-client handover it replaces, it adds:
- a configurable client count,
- skipping of disabled clients,
- a mandatory bus-turnaround cycle after every tenure,
- per-client timeout and overrun error reporting.

The DQ tristate stays in the top level; this block supplies its data and enable.

---
 rtl/audio_mem_pkg.sv | 13 +
 rtl/sram_arb_next_client.sv | 24 ++
 rtl/sram_token_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/audio_mem_pkg.sv
// Shared types and client indices for the audio effect chain's SRAM access path.
package audio_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int unsigned CLI_DELAY = 0;
  localparam int unsigned CLI_LOOP  = 1;

endpackage

// File: rtl/sram_arb_next_client.sv
// Priority finder: lowest set bit of mask at or above index lo (lo = previous owner + 1).
module sram_arb_next_client #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned IDX_W     = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] mask,
  input  logic [IDX_W:0]       lo,
  output logic [IDX_W-1:0]     idx_c,
  output logic                 found_c
);

  // Scanning downward leaves the lowest qualifying index as the final winner.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(lo))) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sram_token_arbiter.sv
// Hands the single external SRAM port to N clients in chain order once per sample,
// with a released-bus turnaround cycle after every tenure and sticky error reporting.
module sram_token_arbiter
  import audio_mem_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                          i_AUD_BCLK,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [N_CLIENTS-1:0]          i_client_en,
  input  logic [N_CLIENTS*ADDR_W-1:0]   i_client_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   i_client_wdata,
  input  logic [N_CLIENTS-1:0]          i_client_we_n,
  input  logic [N_CLIENTS-1:0]          i_client_done,
  input  logic                          i_clr_err,
  output logic [N_CLIENTS-1:0]          o_grant,
  output logic [ADDR_W-1:0]             o_SRAM_ADDR,
  output logic                          o_SRAM_WE_N,
  output logic [DATA_W-1:0]             o_sram_wdata,
  output logic                          o_sram_drive,
  output logic                          o_busy,
  output logic                          o_timeout_err,
  output logic [$clog2(N_CLIENTS)-1:0]  o_err_client,
  output logic                          o_overrun
);

  localparam int unsigned IDX_W = $clog2(N_CLIENTS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     cur;
  logic [N_CLIENTS-1:0] mask_r;
  logic [N_CLIENTS-1:0] grant_r;
  logic [CNT_W-1:0]     cnt;
  logic                 busy_r;
  logic                 terr_r;
  logic                 ovr_r;
  logic [IDX_W-1:0]     err_client_r;

  logic [N_CLIENTS-1:0] search_mask_c;
  logic [IDX_W:0]       search_lo_c;
  logic [IDX_W-1:0]     next_idx_c;
  logic                 next_found_c;

  logic [ADDR_W-1:0]    addr_sel_c;
  logic [DATA_W-1:0]    wdata_sel_c;
  logic                 we_n_sel_c;
  logic                 done_sel_c;
  logic                 owning_c;
  logic                 at_limit_c;
  logic                 tenure_end_c;
  logic                 timeout_hit_c;

  // First grant searches the live enables from index 0; TURN searches the latched mask above cur.
  assign search_mask_c = (state == IDLE) ? i_client_en : mask_r;
  assign search_lo_c   = (state == IDLE) ? '0 : ({1'b0, cur} + (IDX_W + 1)'(1));

  sram_arb_next_client #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_next_client (
    .mask    (search_mask_c),
    .lo      (search_lo_c),
    .idx_c   (next_idx_c),
    .found_c (next_found_c)
  );

  // Select the current owner's request lines.
  always_comb begin
    addr_sel_c  = '0;
    wdata_sel_c = '0;
    we_n_sel_c  = 1'b1;
    done_sel_c  = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (cur == IDX_W'(k)) begin
        addr_sel_c  = i_client_addr[k*ADDR_W +: ADDR_W];
        wdata_sel_c = i_client_wdata[k*DATA_W +: DATA_W];
        we_n_sel_c  = i_client_we_n[k];
        done_sel_c  = i_client_done[k];
      end
    end
  end

  assign owning_c      = (state == GRANT);
  assign at_limit_c    = (cnt == CNT_LAST);
  assign tenure_end_c  = owning_c && (done_sel_c || at_limit_c);
  assign timeout_hit_c = owning_c && at_limit_c && !done_sel_c;

  // Bus outputs follow the owner directly; they fall to idle values with the state flop on reset.
  assign o_SRAM_ADDR   = owning_c ? addr_sel_c  : '0;
  assign o_sram_wdata  = owning_c ? wdata_sel_c : '0;
  assign o_SRAM_WE_N   = owning_c ? we_n_sel_c  : 1'b1;
  assign o_sram_drive  = owning_c && !we_n_sel_c;

  assign o_grant       = grant_r;
  assign o_busy        = busy_r;
  assign o_timeout_err = terr_r;
  assign o_err_client  = err_client_r;
  assign o_overrun     = ovr_r;

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      mask_r       <= '0;
      grant_r      <= '0;
      cnt          <= '0;
      busy_r       <= 1'b0;
      terr_r       <= 1'b0;
      ovr_r        <= 1'b0;
      err_client_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            mask_r <= i_client_en;
            if (next_found_c) begin
              state   <= GRANT;
              cur     <= next_idx_c;
              cnt     <= '0;
              grant_r <= N_CLIENTS'(1) << next_idx_c;
              busy_r  <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (tenure_end_c) begin
            state   <= TURN;
            grant_r <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TURN: begin
          if (next_found_c) begin
            state   <= GRANT;
            cur     <= next_idx_c;
            cnt     <= '0;
            grant_r <= N_CLIENTS'(1) << next_idx_c;
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase

      // A new error in the same cycle as a clear keeps the flag set.
      if (timeout_hit_c) begin
        terr_r       <= 1'b1;
        err_client_r <= cur;
      end else if (i_clr_err) begin
        terr_r <= 1'b0;
      end

      if (i_start && (state != IDLE)) begin
        ovr_r <= 1'b1;
      end else if (i_clr_err) begin
        ovr_r <= 1'b0;
      end
    end
  end

endmodule
